// File: rtl/program_loader.sv
// Boot loader: parses a framed byte stream into imem words and dmem bytes, then raises core_ready.
// Write strobes are registered one cycle after the accepting edge; in_valid gaps stall assembly losslessly.
module program_loader #(
  parameter int IMEM_DEPTH = 256,
  parameter int DMEM_DEPTH = 1024,
  parameter int IA_W       = 8,
  parameter int DA_W       = 10
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_start,
  input  logic            i_in_valid,
  input  logic [7:0]      i_in_byte,
  output logic            o_in_ready,
  output logic            o_imem_we,
  output logic [IA_W-1:0] o_imem_addr,
  output logic [31:0]     o_imem_wdata,
  output logic            o_dmem_we,
  output logic [DA_W-1:0] o_dmem_addr,
  output logic [7:0]      o_dmem_wdata,
  output logic            o_core_ready,
  output logic            o_error
);

  typedef enum logic [2:0] {S_HDR, S_INSTR, S_DATA, S_DONE, S_ERR} state_t;

  localparam logic [15:0] IMEM_LIM = 16'(IMEM_DEPTH);
  localparam logic [15:0] DMEM_LIM = 16'(DMEM_DEPTH);

  state_t            r_state;
  logic              r_armed;
  logic [1:0]        r_hdr_cnt;
  logic [1:0]        r_byte_cnt;
  logic [15:0]       r_icnt;
  logic [15:0]       r_dcnt;
  logic [15:0]       r_widx;
  logic [15:0]       r_didx;
  logic [23:0]       r_word;
  logic              r_imem_we;
  logic [IA_W-1:0]   r_imem_addr;
  logic [31:0]       r_imem_wdata;
  logic              r_dmem_we;
  logic [DA_W-1:0]   r_dmem_addr;
  logic [7:0]        r_dmem_wdata;
  logic              r_core_ready;
  logic              r_error;

  logic              w_accept;
  logic [15:0]       w_dcnt_full;
  logic [31:0]       w_word;

  // r_armed keeps in_ready low while reset is asserted even though the state is HDR.
  assign o_in_ready  = r_armed &&
                       (r_state == S_HDR || r_state == S_INSTR || r_state == S_DATA);
  assign w_accept    = i_in_valid && o_in_ready;
  assign w_dcnt_full = {r_dcnt[7:0], i_in_byte};
  assign w_word      = {r_word, i_in_byte};

  assign o_imem_we    = r_imem_we;
  assign o_imem_addr  = r_imem_addr;
  assign o_imem_wdata = r_imem_wdata;
  assign o_dmem_we    = r_dmem_we;
  assign o_dmem_addr  = r_dmem_addr;
  assign o_dmem_wdata = r_dmem_wdata;
  assign o_core_ready = r_core_ready;
  assign o_error      = r_error;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= S_HDR;
      r_armed      <= 1'b0;
      r_hdr_cnt    <= '0;
      r_byte_cnt   <= '0;
      r_icnt       <= '0;
      r_dcnt       <= '0;
      r_widx       <= '0;
      r_didx       <= '0;
      r_word       <= '0;
      r_imem_we    <= 1'b0;
      r_imem_addr  <= '0;
      r_imem_wdata <= '0;
      r_dmem_we    <= 1'b0;
      r_dmem_addr  <= '0;
      r_dmem_wdata <= '0;
      r_core_ready <= 1'b0;
      r_error      <= 1'b0;
    end else begin
      r_armed   <= 1'b1;
      r_imem_we <= 1'b0;
      r_dmem_we <= 1'b0;
      if ((r_state == S_DONE || r_state == S_ERR) && i_start) begin
        r_state      <= S_HDR;
        r_hdr_cnt    <= '0;
        r_byte_cnt   <= '0;
        r_icnt       <= '0;
        r_dcnt       <= '0;
        r_widx       <= '0;
        r_didx       <= '0;
        r_word       <= '0;
        r_imem_addr  <= '0;
        r_imem_wdata <= '0;
        r_dmem_addr  <= '0;
        r_dmem_wdata <= '0;
        r_core_ready <= 1'b0;
        r_error      <= 1'b0;
      end else begin
        case (r_state)
          S_HDR: begin
            if (w_accept) begin
              r_hdr_cnt <= r_hdr_cnt + 2'd1;
              if (r_hdr_cnt < 2'd2) r_icnt <= {r_icnt[7:0], i_in_byte};
              else                  r_dcnt <= w_dcnt_full;
              if (r_hdr_cnt == 2'd3) begin
                if (r_icnt > IMEM_LIM || w_dcnt_full > DMEM_LIM) begin
                  r_state <= S_ERR;
                  r_error <= 1'b1;
                end else if (r_icnt != 16'd0) begin
                  r_state <= S_INSTR;
                end else if (w_dcnt_full != 16'd0) begin
                  r_state <= S_DATA;
                end else begin
                  // Empty frame: no final strobe to wait for, so ready rises with the header.
                  r_state      <= S_DONE;
                  r_core_ready <= 1'b1;
                end
              end
            end
          end
          S_INSTR: begin
            if (w_accept) begin
              r_byte_cnt <= r_byte_cnt + 2'd1;
              r_word     <= w_word[23:0];
              if (r_byte_cnt == 2'd3) begin
                r_imem_we    <= 1'b1;
                r_imem_wdata <= w_word;
                r_imem_addr  <= r_widx[IA_W-1:0];
                r_widx       <= r_widx + 16'd1;
                if (r_widx == r_icnt - 16'd1)
                  r_state <= (r_dcnt != 16'd0) ? S_DATA : S_DONE;
              end
            end
          end
          S_DATA: begin
            if (w_accept) begin
              r_dmem_we    <= 1'b1;
              r_dmem_addr  <= r_didx[DA_W-1:0];
              r_dmem_wdata <= i_in_byte;
              r_didx       <= r_didx + 16'd1;
              if (r_didx == r_dcnt - 16'd1) r_state <= S_DONE;
            end
          end
          S_DONE:  r_core_ready <= 1'b1;
          S_ERR:   r_error      <= 1'b1;
          default: r_state      <= S_HDR;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: scoreboard of expected memory writes, one task per scenario.
module tb_program_loader;
  localparam int IA_W = 8;
  localparam int DA_W = 10;

  logic            clk      = 1'b0;
  logic            rst_n    = 1'b1;
  logic            start    = 1'b0;
  logic            in_valid = 1'b0;
  logic [7:0]      in_byte  = 8'h00;
  logic            in_ready;
  logic            imem_we;
  logic [IA_W-1:0] imem_addr;
  logic [31:0]     imem_wdata;
  logic            dmem_we;
  logic [DA_W-1:0] dmem_addr;
  logic [7:0]      dmem_wdata;
  logic            core_ready;
  logic            error;

  program_loader #(.IMEM_DEPTH(256), .DMEM_DEPTH(1024), .IA_W(IA_W), .DA_W(DA_W)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_in_valid(in_valid),
    .i_in_byte(in_byte), .o_in_ready(in_ready), .o_imem_we(imem_we),
    .o_imem_addr(imem_addr), .o_imem_wdata(imem_wdata), .o_dmem_we(dmem_we),
    .o_dmem_addr(dmem_addr), .o_dmem_wdata(dmem_wdata), .o_core_ready(core_ready),
    .o_error(error)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        is_d;
    logic [15:0] addr;
    logic [31:0] data;
  } exp_t;

  int          n_checks = 0;
  int          n_errors = 0;
  exp_t        exp_q[$];
  logic [7:0]  bq[$];
  exp_t        m_exp;
  exp_t        m_got;

  // Strobe monitor: every write strobe must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n) begin
      if (imem_we && dmem_we) begin
        n_checks++;
        n_errors++;
        $display("FAIL both_we imem_we=%0b dmem_we=%0b required not both 1", imem_we, dmem_we);
      end else if (imem_we || dmem_we) begin
        n_checks++;
        m_got.is_d = dmem_we;
        m_got.addr = dmem_we ? 16'(dmem_addr) : 16'(imem_addr);
        m_got.data = dmem_we ? {24'h0, dmem_wdata} : imem_wdata;
        if (exp_q.size() == 0) begin
          n_errors++;
          $display("FAIL strobe_unexpected got is_d=%0b addr=%0d data=%h required no strobe",
                   m_got.is_d, m_got.addr, m_got.data);
        end else begin
          m_exp = exp_q.pop_front();
          if (m_got !== m_exp) begin
            n_errors++;
            $display("FAIL strobe got is_d=%0b addr=%0d data=%h required is_d=%0b addr=%0d data=%h",
                     m_got.is_d, m_got.addr, m_got.data, m_exp.is_d, m_exp.addr, m_exp.data);
          end
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    @(negedge clk);
    repeat (gap) @(negedge clk);
    in_valid = 1'b1;
    in_byte  = b;
    t = 0;
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      n_checks++;
      n_errors++;
      $display("FAIL send_timeout in_ready=%0b required 1 within 50 cycles", in_ready);
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      in_valid = 1'b0;
    end
  endtask

  task automatic send_all(input int gapmax);
    foreach (bq[i]) send_byte(bq[i], (gapmax > 0) ? int'($urandom_range(gapmax, 0)) : 0);
  endtask

  // Reference parse of the frame held in bq.
  task automatic push_model();
    int icnt;
    int dcnt;
    icnt = {bq[0], bq[1]};
    dcnt = {bq[2], bq[3]};
    if (icnt > 256 || dcnt > 1024) return;
    for (int w = 0; w < icnt; w++)
      exp_q.push_back('{1'b0, 16'(w),
                        {bq[4+4*w], bq[5+4*w], bq[6+4*w], bq[7+4*w]}});
    for (int d = 0; d < dcnt; d++)
      exp_q.push_back('{1'b1, 16'(d), {24'h0, bq[4+4*icnt+d]}});
  endtask

  task automatic set_frame1();
    bq = '{8'h00, 8'h02, 8'h00, 8'h01, 8'h20, 8'h10, 8'h00, 8'h32,
           8'h20, 8'h11, 8'hFF, 8'h9C, 8'hA5};
  endtask

  task automatic wait_core_ready(input string name);
    int t;
    t = 0;
    while (!core_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    n_checks++;
    if (core_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL %s core_ready=%0b required 1 within 50 cycles", name, core_ready);
    end
  endtask

  task automatic check_drained(input string name);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL %s pending_writes=%0d required 0", name, exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #2;
    n_checks++;
    if ({in_ready, imem_we, dmem_we, core_ready, error} !== 5'b0) begin
      n_errors++;
      $display("FAIL reset_outputs got rdy/iwe/dwe/cr/err=%b required 00000",
               {in_ready, imem_we, dmem_we, core_ready, error});
    end
    n_checks++;
    if (imem_addr !== '0 || dmem_addr !== '0 || imem_wdata !== '0 || dmem_wdata !== '0) begin
      n_errors++;
      $display("FAIL reset_bus got ia=%0d da=%0d iw=%h dw=%h required all 0",
               imem_addr, dmem_addr, imem_wdata, dmem_wdata);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({in_ready, core_ready, error} !== 3'b100) begin
      n_errors++;
      $display("FAIL reset_release got rdy/cr/err=%b required 100", {in_ready, core_ready, error});
    end
  endtask

  task automatic test_basic();
    exp_q.push_back('{1'b0, 16'd0, 32'h20100032});
    exp_q.push_back('{1'b0, 16'd1, 32'h2011FF9C});
    exp_q.push_back('{1'b1, 16'd0, 32'h000000A5});
    set_frame1();
    send_all(0);
    @(negedge clk);
    n_checks++;
    if (dmem_we !== 1'b1 || core_ready !== 1'b0) begin
      n_errors++;
      $display("FAIL basic_last_strobe dmem_we=%0b core_ready=%0b required 1 0", dmem_we, core_ready);
    end
    @(negedge clk);
    n_checks++;
    if (core_ready !== 1'b1 || dmem_we !== 1'b0 || in_ready !== 1'b0) begin
      n_errors++;
      $display("FAIL basic_core_ready cr=%0b dwe=%0b rdy=%0b required 1 0 0",
               core_ready, dmem_we, in_ready);
    end
    check_drained("basic_drained");
  endtask

  task automatic test_gaps();
    pulse_start();
    set_frame1();
    push_model();
    send_all(5);
    wait_core_ready("gaps_core_ready");
    repeat (3) @(negedge clk);
    check_drained("gaps_drained");
  endtask

  task automatic test_zero_hdr();
    pulse_start();
    bq = '{8'h00, 8'h00, 8'h00, 8'h00};
    push_model();
    send_all(0);
    @(negedge clk);
    n_checks++;
    if (core_ready !== 1'b1 || in_ready !== 1'b0) begin
      n_errors++;
      $display("FAIL zero_hdr core_ready=%0b in_ready=%0b required 1 0", core_ready, in_ready);
    end
    repeat (3) @(negedge clk);
    n_checks++;
    if (core_ready !== 1'b1 || in_ready !== 1'b0) begin
      n_errors++;
      $display("FAIL zero_hdr_hold core_ready=%0b in_ready=%0b required 1 0", core_ready, in_ready);
    end
    check_drained("zero_hdr_drained");
  endtask

  task automatic test_err_restart(input logic [7:0] b0, input logic [7:0] b1,
                                  input logic [7:0] b2, input logic [7:0] b3);
    pulse_start();
    bq = '{b0, b1, b2, b3};
    push_model();
    send_all(0);
    @(negedge clk);
    n_checks++;
    if (error !== 1'b1 || in_ready !== 1'b0 || core_ready !== 1'b0) begin
      n_errors++;
      $display("FAIL err_hdr %h%h%h%h error=%0b in_ready=%0b cr=%0b required 1 0 0",
               b0, b1, b2, b3, error, in_ready, core_ready);
    end
    repeat (4) @(negedge clk);
    n_checks++;
    if (error !== 1'b1 || in_ready !== 1'b0) begin
      n_errors++;
      $display("FAIL err_hold error=%0b in_ready=%0b required 1 0", error, in_ready);
    end
    pulse_start();
    n_checks++;
    if (error !== 1'b0 || in_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL err_restart error=%0b in_ready=%0b required 0 1", error, in_ready);
    end
    set_frame1();
    push_model();
    send_all(0);
    wait_core_ready("err_reload_ready");
    check_drained("err_reload_drained");
  endtask

  task automatic test_mid_reset();
    pulse_start();
    exp_q.push_back('{1'b0, 16'd0, 32'hDEADBEEF});
    bq = '{8'h00, 8'h02, 8'h00, 8'h00, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h11, 8'h22};
    send_all(0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({in_ready, imem_we, dmem_we, core_ready, error} !== 5'b0 || imem_addr !== '0 ||
        imem_wdata !== '0) begin
      n_errors++;
      $display("FAIL midreset_outputs rdy/iwe/dwe/cr/err=%b ia=%0d iw=%h required all 0",
               {in_ready, imem_we, dmem_we, core_ready, error}, imem_addr, imem_wdata);
    end
    check_drained("midreset_drained");
    @(negedge clk);
    rst_n = 1'b1;
    set_frame1();
    push_model();
    send_all(0);
    wait_core_ready("midreset_reload_ready");
    check_drained("midreset_reload_drained");
  endtask

  task automatic test_full_depth();
    pulse_start();
    bq = '{8'h01, 8'h00, 8'h04, 8'h00};
    for (int i = 0; i < 2048; i++) bq.push_back(8'($urandom));
    push_model();
    send_all(0);
    @(negedge clk);
    n_checks++;
    if (dmem_we !== 1'b1 || dmem_addr !== 10'd1023 || core_ready !== 1'b0) begin
      n_errors++;
      $display("FAIL full_last dwe=%0b dmem_addr=%0d cr=%0b required 1 1023 0",
               dmem_we, dmem_addr, core_ready);
    end
    wait_core_ready("full_core_ready");
    check_drained("full_drained");
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_gaps();
    test_zero_hdr();
    test_err_restart(8'h01, 8'h01, 8'h00, 8'h00);
    test_err_restart(8'h00, 8'h00, 8'h04, 8'h01);
    test_mid_reset();
    test_full_depth();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
